// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and the code-to-key decode for the keypad decoder.
package keypad_pkg;
  typedef enum logic [1:0] {DIGIT, LETTER, STAR, HASH} key_class_t;
  typedef enum logic [2:0] {IDLE, DEBOUNCE, EMIT, WAIT_RELEASE, RELEASE_DB} dec_state_t;
  typedef struct packed {
    logic       ok;
    logic [3:0] value;
    key_class_t cls;
  } key_dec_t;
  // Nibble at index {row,col} holds the key value; row 0 is the least significant 16 bits.
  localparam logic [63:0] KEY_MAP = 64'hDF0E_C987_B654_A321;
  function automatic logic [2:0] low_index(input logic [3:0] n);
    return n == 4'b1110 ? 3'b100 :
           n == 4'b1101 ? 3'b101 :
           n == 4'b1011 ? 3'b110 :
           n == 4'b0111 ? 3'b111 : 3'b000;
  endfunction
  function automatic key_dec_t decode_key(input logic [7:0] code);
    logic [2:0] c;
    logic [2:0] r;
    key_dec_t   d;
    c       = low_index(code[7:4]);
    r       = low_index(code[3:0]);
    d.ok    = c[2] & r[2];
    d.value = KEY_MAP[{r[1:0], c[1:0], 2'b00} +: 4];
    d.cls   = c[1:0] == 2'd3 ? LETTER :
              r[1:0] != 2'd3 ? DIGIT  :
              c[1:0] == 2'd0 ? STAR   :
              c[1:0] == 2'd2 ? HASH   : DIGIT;
    return d;
  endfunction
endpackage

// File: rtl/keypad_decoder_fifo.sv
// keypad_fifo: small event queue with wrap-bit pointers and a combinational head.
module keypad_fifo #(
  parameter int W     = 6,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head_data,
  output logic         empty,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0]  r_wr;
  logic [AW:0]  r_rd;
  logic [W-1:0] r_mem [DEPTH];
  logic         w_do_push;
  logic         w_do_pop;
  assign empty     = r_wr == r_rd;
  assign full      = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push at full is still accepted.
  assign w_do_push = push && (!full || w_do_pop);
  assign head_data = r_mem[r_rd[AW-1:0]];
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr[AW-1:0]] <= push_data;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      if (w_do_push) r_wr <= r_wr + (AW+1)'(1);
      if (w_do_pop) r_rd <= r_rd + (AW+1)'(1);
    end
  end
endmodule

// File: rtl/keypad_decoder.sv
// keypad_decoder: debounces scanner codes and queues one decoded event per press.
module keypad_decoder
  import keypad_pkg::*;
#(
  parameter int CLK_FREQ    = 27_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       clk_27mhz,
  input  logic       reset,
  input  logic       key_pressed,
  input  logic [7:0] key_code_raw,
  input  logic       key_ready,
  output logic       key_valid,
  output logic [3:0] key_value,
  output logic [1:0] key_class,
  output logic       key_error,
  output logic       fifo_overflow
);
  localparam int DB_CYCLES = (CLK_FREQ / 1000) * DEBOUNCE_MS;
  localparam int CW        = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);
  dec_state_t    r_state;
  logic [7:0]    r_cap;
  logic [CW-1:0] r_cnt;
  logic          r_error;
  logic          r_overflow;
  key_dec_t      w_dec;
  logic          w_push;
  logic          w_empty;
  logic          w_full;
  logic [5:0]    w_head;
  assign w_dec  = decode_key(r_cap);
  assign w_push = r_state == EMIT && w_dec.ok;
  keypad_fifo #(.W(6), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk_27mhz),
    .rst       (reset),
    .push      (w_push),
    .push_data ({w_dec.value, w_dec.cls}),
    .pop       (key_ready),
    .head_data (w_head),
    .empty     (w_empty),
    .full      (w_full)
  );
  assign key_valid     = !w_empty;
  assign key_value     = w_empty ? 4'h0 : w_head[5:2];
  assign key_class     = w_empty ? 2'd0 : w_head[1:0];
  assign key_error     = r_error;
  assign fifo_overflow = r_overflow;
  always_ff @(posedge clk_27mhz) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cap      <= '0;
      r_cnt      <= '0;
      r_error    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      r_error    <= r_state == EMIT && !w_dec.ok;
      r_overflow <= r_overflow | (w_push & w_full & ~key_ready);
      case (r_state)
        IDLE:
          if (key_pressed) begin
            r_cap   <= key_code_raw;
            r_cnt   <= '0;
            r_state <= DEBOUNCE;
          end
        DEBOUNCE:
          if (!key_pressed || key_code_raw != r_cap) r_state <= IDLE;
          else if (r_cnt == DB_LAST) r_state <= EMIT;
          else r_cnt <= r_cnt + CW'(1);
        EMIT: r_state <= WAIT_RELEASE;
        WAIT_RELEASE:
          if (!key_pressed) begin
            r_cnt   <= '0;
            r_state <= RELEASE_DB;
          end
        RELEASE_DB:
          if (key_pressed) r_state <= WAIT_RELEASE;
          else if (r_cnt == DB_LAST) r_state <= IDLE;
          else r_cnt <= r_cnt + CW'(1);
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
